spi_master: RTL and testbench

- Serial engine downstream of the UART command processor.
- Consumes the processor's spi_start/spi_dir/spi_data_tx/spi_data_depth request and drives a 4-wire SPI bus (mode 0, MSB first) toward the RFFE bridge.
- Write transfers shift out spi_data_depth bits; read transfers shift out the address bits, then capture RD_BITS bits from MISO and return them with a valid pulse.
- spi_ready tells the processor when a new request is accepted.

---
 rtl/spi_master.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode 0 (MSB first) serial engine fed by the UART command
// processor and driving the RFFE bridge.
//
// A request (spi_start while spi_ready) latches direction, payload and depth.
// Depth is clamped to 24 bits; a depth of 0 is ignored.
// - Write: shift out depth bits.
// - Read: shift out depth address bits, then clock RD_BITS bits in from MISO.
//   The captured value is presented on spi_data_rx with a single-cycle
//   spi_rx_valid pulse when chip select is released.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   spi_start         request strobe (sampled only while spi_ready=1)
//   spi_dir           0=write, 1=read
//   spi_data_tx[23:0] payload, bit (depth-1) is sent first
//   spi_data_depth    number of bits to shift out (clamped to 24)
//   spi_ready         idle and able to accept a request
//   spi_data_rx[15:0] last captured read data, right-aligned
//   spi_rx_valid      one-cycle pulse when spi_data_rx updates
//   spi_cs_n, spi_sclk, spi_mosi, spi_miso   4-wire SPI bus
//
// Build option: SPI_CS_GUARD_EN stretches HOLD to 3*CLK_DIV cycles and GAP to
// 2*CLK_DIV cycles, giving margin for slow select logic on the bridge.
//
// state | meaning
// IDLE  | ready for a request, cs_n high
// SETUP | cs_n low, first bit on MOSI, waiting one half-period
// SHIFT | clocking out the latched bits
// READ  | clocking in RD_BITS bits from MISO (reads only)
// HOLD  | sclk low, cs_n still low
// GAP   | cs_n high before returning to IDLE
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int RD_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_start,
    input  logic        spi_dir,
    input  logic [23:0] spi_data_tx,
    input  logic [7:0]  spi_data_depth,
    output logic        spi_ready,
    output logic [15:0] spi_data_rx,
    output logic        spi_rx_valid,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

`ifdef SPI_CS_GUARD_EN
    localparam int HOLD_CYC = 3 * CLK_DIV;
    localparam int GAP_CYC  = 2 * CLK_DIV;
`else
    localparam int HOLD_CYC = CLK_DIV;
    localparam int GAP_CYC  = 1;
`endif

    localparam logic [9:0] HALF_LAST = 10'(CLK_DIV - 1);
    localparam logic [9:0] HOLD_LAST = 10'(HOLD_CYC - 1);
    localparam logic [9:0] GAP_LAST  = 10'(GAP_CYC - 1);
    localparam logic [4:0] RD_LAST   = 5'(RD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        READ,
        HOLD,
        GAP
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [4:0]  rd_q, rd_d;
    logic        dir_q, dir_d;
    logic [23:0] tx_q, tx_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] rx_q, rx_d;
    logic        valid_q, valid_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;

    logic [4:0]  depth_c;
    logic        half_done;

    assign depth_c   = (spi_data_depth > 8'd24) ? 5'd24 : spi_data_depth[4:0];
    assign half_done = (cnt_q == HALF_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        rd_d    = rd_q;
        dir_d   = dir_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        valid_d = 1'b0;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;

        case (state_q)
            IDLE: begin
                if (spi_start && (spi_data_depth != 8'd0)) begin
                    dir_d   = spi_dir;
                    tx_d    = spi_data_tx;
                    bit_d   = depth_c - 5'd1;
                    mosi_d  = spi_data_tx[depth_c - 5'd1];
                    shift_d = '0;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_done) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            SHIFT: begin
                if (!half_done) begin
                    cnt_d = cnt_q + 10'd1;
                end else begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // falling edge: present the next bit for the coming rise
                        sclk_d = 1'b0;
                        if (bit_q != 5'd0) begin
                            mosi_d = tx_q[bit_q - 5'd1];
                        end
                    end else if (bit_q != 5'd0) begin
                        bit_d  = bit_q - 5'd1;
                        sclk_d = 1'b1;
                    end else if (dir_q) begin
                        // first read period starts immediately; sample on this rise
                        sclk_d  = 1'b1;
                        mosi_d  = 1'b0;
                        rd_d    = RD_LAST;
                        shift_d = {shift_q[14:0], spi_miso};
                        state_d = READ;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            READ: begin
                if (!half_done) begin
                    cnt_d = cnt_q + 10'd1;
                end else begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (rd_q != 5'd0) begin
                        rd_d    = rd_q - 5'd1;
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[14:0], spi_miso};
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                    if (dir_q) begin
                        rx_d    = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            rd_q    <= '0;
            dir_q   <= 1'b0;
            tx_q    <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            valid_q <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            dir_q   <= dir_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            valid_q <= valid_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    assign spi_ready    = (state_q == IDLE);
    assign spi_data_rx  = rx_q;
    assign spi_rx_valid = valid_q;
    assign spi_cs_n     = cs_n_q;
    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

    localparam int CD = 2;
    localparam int RB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_start = 1'b0;
    logic        spi_dir = 1'b0;
    logic [23:0] spi_data_tx = '0;
    logic [7:0]  spi_data_depth = '0;
    logic        spi_ready;
    logic [15:0] spi_data_rx;
    logic        spi_rx_valid;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    spi_master #(.CLK_DIV(CD), .RD_BITS(RB)) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_start      (spi_start),
        .spi_dir        (spi_dir),
        .spi_data_tx    (spi_data_tx),
        .spi_data_depth (spi_data_depth),
        .spi_ready      (spi_ready),
        .spi_data_rx    (spi_data_rx),
        .spi_rx_valid   (spi_rx_valid),
        .spi_cs_n       (spi_cs_n),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cs_low;
        int          rises;
        logic [63:0] mosi;
        logic        valid_end;
        logic [15:0] rx;
        int          gap;
    } frame_t;

    frame_t exp_q[$];
    frame_t obs_q[$];

    int checks = 0;
    int failures = 0;
    int vcnt = 0;
    int frames = 0;

    frame_t cur;
    bit     in_frame = 1'b0;
    int     hi_cnt = 0;
    logic   prev_sclk = 1'b0;
    logic [15:0] miso_data = '0;
    int     m_depth = 0;

    // Bus monitor: samples on the falling clk edge and records one frame per cs_n low period.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_frame  = 1'b0;
            hi_cnt    = 0;
            prev_sclk = 1'b0;
        end else begin
            if (spi_rx_valid) vcnt++;
            if (!spi_cs_n) begin
                if (!in_frame) begin
                    in_frame      = 1'b1;
                    cur.cs_low    = 0;
                    cur.rises     = 0;
                    cur.mosi      = '0;
                    cur.valid_end = 1'b0;
                    cur.rx        = '0;
                    cur.gap       = hi_cnt;
                end
                cur.cs_low++;
                if (spi_sclk && !prev_sclk) begin
                    cur.rises++;
                    cur.mosi = {cur.mosi[62:0], spi_mosi};
                end
            end else begin
                if (in_frame) begin
                    cur.valid_end = spi_rx_valid;
                    cur.rx        = spi_data_rx;
                    obs_q.push_back(cur);
                    frames++;
                    in_frame = 1'b0;
                    hi_cnt   = 0;
                end
                hi_cnt++;
            end
            prev_sclk = spi_sclk;
        end
    end

    // Mode-0 slave: after the address bits, present read data MSB first on each sclk fall.
    initial forever begin
        int idx;
        @(negedge spi_sclk);
        idx = cur.rises - m_depth;
        if (in_frame && idx >= 0 && idx < RB) spi_miso = miso_data[RB - 1 - idx];
        else spi_miso = 1'b0;
    end

    // Caller is positioned just after a falling clk edge.
    task automatic send_req(input bit dir, input int depth, input logic [23:0] tx);
        frame_t e;
        int d;
        spi_dir        = dir;
        spi_data_depth = depth[7:0];
        spi_data_tx    = tx;
        spi_start      = 1'b1;
        if (spi_ready && depth != 0) begin
            d = (depth > 24) ? 24 : depth;
            e.mosi = '0;
            for (int i = d - 1; i >= 0; i--) e.mosi = {e.mosi[62:0], tx[i]};
            if (dir) for (int i = 0; i < RB; i++) e.mosi = {e.mosi[62:0], 1'b0};
            e.rises     = d + (dir ? RB : 0);
            e.cs_low    = CD * (2 + 2 * d + 2 * RB * (dir ? 1 : 0));
            e.valid_end = dir;
            e.rx        = dir ? (miso_data & 16'((1 << RB) - 1)) : 16'h0;
            e.gap       = 0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        spi_start = 1'b0;
    endtask

    task automatic wait_frame(output frame_t f, output bit ok);
        ok = 1'b0;
        f  = cur;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() > 0) begin
                f  = obs_q.pop_front();
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: no frame observed within 3000 cycles, required one frame");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (spi_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", spi_ready); end
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk: got %b want 0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi: got %b want 0", spi_mosi); end
        checks++; if (spi_rx_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", spi_rx_valid); end
        checks++; if (spi_data_rx !== 16'h0) begin failures++; $display("FAIL rst_rx: got %h want 0000", spi_data_rx); end
        rst = 1'b0;
    endtask

    task automatic test_write16();
        frame_t o, e;
        bit ok;
        int v0 = vcnt;
        @(negedge clk);
        send_req(1'b0, 16, 24'h00A55A);
        wait_frame(o, ok);
        e = exp_q.pop_front();
        if (ok) begin
            checks++; if (o.mosi[15:0] !== 16'b1010010101011010) begin failures++; $display("FAIL w16_mosi_pattern: got %b want 1010010101011010", o.mosi[15:0]); end
            checks++; if (o.mosi !== e.mosi) begin failures++; $display("FAIL w16_mosi: got %h want %h", o.mosi, e.mosi); end
            checks++; if (o.cs_low !== 68) begin failures++; $display("FAIL w16_cs_low: got %0d want 68", o.cs_low); end
            checks++; if (o.rises !== 16) begin failures++; $display("FAIL w16_rises: got %0d want 16", o.rises); end
            checks++; if (o.valid_end !== 1'b0) begin failures++; $display("FAIL w16_valid: got %b want 0", o.valid_end); end
            checks++; if (spi_ready !== 1'b0) begin failures++; $display("FAIL w16_ready_gap: got %b want 0", spi_ready); end
            @(negedge clk);
            checks++; if (spi_ready !== 1'b1) begin failures++; $display("FAIL w16_ready_back: got %b want 1", spi_ready); end
            checks++; if (vcnt !== v0) begin failures++; $display("FAIL w16_no_valid: got %0d pulses want 0", vcnt - v0); end
        end
    endtask

    task automatic test_clamp();
        frame_t o, e;
        bit ok;
        @(negedge clk);
        send_req(1'b0, 30, 24'hFFFFFF);
        wait_frame(o, ok);
        e = exp_q.pop_front();
        if (ok) begin
            checks++; if (o.rises !== 24) begin failures++; $display("FAIL clamp_rises: got %0d want 24", o.rises); end
            checks++; if (o.mosi !== 64'hFFFFFF) begin failures++; $display("FAIL clamp_mosi: got %h want 0000000000ffffff", o.mosi); end
            checks++; if (o.cs_low !== 100) begin failures++; $display("FAIL clamp_cs_low: got %0d want 100", o.cs_low); end
            checks++; if (o.cs_low !== e.cs_low) begin failures++; $display("FAIL clamp_model_cs: got %0d want %0d", o.cs_low, e.cs_low); end
        end
    endtask

    task automatic test_read();
        frame_t o, e;
        bit ok;
        int v0 = vcnt;
        miso_data = 16'h005A;
        m_depth   = 8;
        @(negedge clk);
        send_req(1'b1, 8, 24'h0000C3);
        wait_frame(o, ok);
        e = exp_q.pop_front();
        if (ok) begin
            checks++; if (o.mosi[15:0] !== 16'hC300) begin failures++; $display("FAIL rd_mosi: got %h want c300", o.mosi[15:0]); end
            checks++; if (o.rises !== e.rises) begin failures++; $display("FAIL rd_rises: got %0d want %0d", o.rises, e.rises); end
            checks++; if (o.cs_low !== e.cs_low) begin failures++; $display("FAIL rd_cs_low: got %0d want %0d", o.cs_low, e.cs_low); end
            checks++; if (o.valid_end !== 1'b1) begin failures++; $display("FAIL rd_valid_edge: got %b want 1", o.valid_end); end
            checks++; if (o.rx !== 16'h005A) begin failures++; $display("FAIL rd_data: got %h want 005a", o.rx); end
            @(negedge clk);
            checks++; if (spi_rx_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_width: got %b want 0", spi_rx_valid); end
            repeat (20) @(negedge clk);
            checks++; if (vcnt - v0 !== 1) begin failures++; $display("FAIL rd_valid_count: got %0d want 1", vcnt - v0); end
            checks++; if (spi_data_rx !== 16'h005A) begin failures++; $display("FAIL rd_hold: got %h want 005a", spi_data_rx); end
        end
        m_depth = 0;
    endtask

    task automatic test_ignore();
        frame_t o, e;
        bit ok;
        int f0;
        bit bad;
        @(negedge clk);
        send_req(1'b0, 8, 24'h0000A5);
        for (int i = 0; i < 5; i++) begin
            repeat (3) @(negedge clk);
            send_req(1'b1, 12, 24'h123456);
        end
        wait_frame(o, ok);
        e = exp_q.pop_front();
        if (ok) begin
            checks++; if (o.mosi !== e.mosi) begin failures++; $display("FAIL ign_mosi: got %h want %h", o.mosi, e.mosi); end
            checks++; if (o.cs_low !== e.cs_low) begin failures++; $display("FAIL ign_cs_low: got %0d want %0d", o.cs_low, e.cs_low); end
        end
        f0 = frames;
        repeat (100) @(negedge clk);
        checks++; if (frames !== f0 || obs_q.size() !== 0) begin failures++; $display("FAIL ign_no_extra: got %0d extra frames want 0", frames - f0); end
        send_req(1'b0, 0, 24'hFFFFFF);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (spi_ready !== 1'b1 || spi_cs_n !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad) begin failures++; $display("FAIL depth0_idle: got ready/cs_n disturbed want both held 1"); end
        checks++; if (frames !== f0) begin failures++; $display("FAIL depth0_frame: got %0d frames want 0", frames - f0); end
    endtask

    task automatic test_reset_mid();
        frame_t o, e;
        bit ok;
        bit reached;
        int v0;
        @(negedge clk);
        send_req(1'b0, 24, 24'hABCDEF);
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (in_frame && cur.rises == 10) reached = 1'b1;
        end
        checks++; if (!reached) begin failures++; $display("FAIL rmid_reach: bit 10 not reached want reached"); end
        v0  = vcnt;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL rmid_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin failures++; $display("FAIL rmid_sclk: got %b want 0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL rmid_mosi: got %b want 0", spi_mosi); end
        checks++; if (spi_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b want 1", spi_ready); end
        checks++; if (spi_rx_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b want 0", spi_rx_valid); end
        checks++; if (spi_data_rx !== 16'h0) begin failures++; $display("FAIL rmid_rx: got %h want 0000", spi_data_rx); end
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        send_req(1'b0, 8, 24'h00003C);
        wait_frame(o, ok);
        e = exp_q.pop_front();
        if (ok) begin
            checks++; if (o.mosi !== e.mosi) begin failures++; $display("FAIL rmid_after_mosi: got %h want %h", o.mosi, e.mosi); end
            checks++; if (o.cs_low !== e.cs_low) begin failures++; $display("FAIL rmid_after_cs: got %0d want %0d", o.cs_low, e.cs_low); end
        end
        checks++; if (vcnt !== v0) begin failures++; $display("FAIL rmid_no_valid: got %0d pulses want 0", vcnt - v0); end
    endtask

    task automatic test_back_to_back();
        frame_t o1, o2, e1, e2;
        bit ok1, ok2;
        bit seen;
        @(negedge clk);
        send_req(1'b0, 4, 24'h000009);
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (spi_ready) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_ready: never returned want ready"); end
        send_req(1'b0, 6, 24'h00002D);
        wait_frame(o1, ok1);
        wait_frame(o2, ok2);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        if (ok1 && ok2) begin
            checks++; if (o1.mosi !== e1.mosi) begin failures++; $display("FAIL b2b_mosi1: got %h want %h", o1.mosi, e1.mosi); end
            checks++; if (o2.mosi !== e2.mosi) begin failures++; $display("FAIL b2b_mosi2: got %h want %h", o2.mosi, e2.mosi); end
            checks++; if (o2.cs_low !== e2.cs_low) begin failures++; $display("FAIL b2b_cs2: got %0d want %0d", o2.cs_low, e2.cs_low); end
            checks++; if (o2.gap !== 2) begin failures++; $display("FAIL b2b_gap: got %0d want 2", o2.gap); end
        end
    endtask

    initial begin
        test_reset();
        test_write16();
        test_clamp();
        test_read();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
